imem_loader: RTL

Boot-time program loader that writes an instruction image into `instr_mem` through its load port (`adr`/`load`/`in`). Accepts a byte stream over a valid/ready handshake: a 4-byte little-endian word-count header followed by the program words, little-endian. Each word is assembled and written with a single-cycle `load` pulse. Sits between the host byte source (UART receiver or testbench) and `instr_mem`. The CPU core is held off via `busy` until `done`.

---
 rtl/imem_pkg.sv | 28 ++
 rtl/byte_to_word.sv | 42 ++++
 rtl/imem_loader.sv | 122 ++++++++++++
 3 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader and instr_mem:
// loader state encoding and the default memory depth.
package imem_pkg;

  localparam int unsigned MEM_SIZE_DEFAULT = 1024;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_HDR   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  // Header decision: zero words finishes at once, oversize images are rejected.
  function automatic state_e hdr_next_state(input logic [31:0] n,
                                            input logic [31:0] mem_size);
    if (n == 32'd0) begin
      return S_DONE;
    end else if (n > mem_size) begin
      return S_ERR;
    end else begin
      return S_DATA;
    end
  endfunction

endpackage

// File: rtl/byte_to_word.sv
// Little-endian byte-to-word assembler shared by header and data phases.
// word_valid flags the cycle the 4th byte is accepted; word then holds all 4 bytes.
module byte_to_word (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clear) begin
      idx_d  = 2'd0;
      word_d = 32'd0;
    end else if (byte_valid) begin
      idx_d  = idx_q + 2'd1;
      word_d = {byte_data, word_q[31:8]};
    end
  end

  // Byte 0 ends up in [7:0] after four right-shifts.
  assign word       = {byte_data, word_q[31:8]};
  assign word_valid = byte_valid && !clear && (idx_q == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      idx_q  <= idx_d;
      word_q <= word_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Boot-time loader: word-count header then program words over a byte
// handshake, each word written to instr_mem with a single-cycle load pulse.
//
// state   | meaning
// IDLE    | waiting for start after reset
// HDR     | collecting the 4-byte word count
// DATA    | collecting the 4 bytes of the next word
// WRITE   | load pulse to instr_mem, byte input stalled
// DONE    | image complete, waiting for start
// ERR     | header too large, waiting for start
module imem_loader
  import imem_pkg::*;
#(
  parameter int unsigned MEM_SIZE = MEM_SIZE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [31:0] mem_adr,
  output logic        mem_load,
  output logic [31:0] mem_in,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] words_written
);

  state_e      state_q, state_d;
  logic [31:0] n_q, n_d;
  logic [31:0] ww_q, ww_d;
  logic [31:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_in_q, mem_in_d;
  logic [31:0] ww_inc;

  logic        start_ok;
  logic        accept;
  logic [31:0] asm_word;
  logic        asm_valid;

  assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                              (state_q == S_ERR));
  assign in_ready = rst_n && ((state_q == S_HDR) || (state_q == S_DATA));
  assign accept   = in_ready && in_valid;
  assign ww_inc   = ww_q + 32'd1;

  byte_to_word u_b2w (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (start_ok),
    .byte_valid (accept),
    .byte_data  (in_data),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    ww_d      = ww_q;
    mem_adr_d = mem_adr_q;
    mem_in_d  = mem_in_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_ok) begin
          state_d   = S_HDR;
          ww_d      = 32'd0;
          mem_adr_d = 32'd0;
        end
      end
      S_HDR: begin
        if (asm_valid) begin
          n_d     = asm_word;
          state_d = hdr_next_state(asm_word, MEM_SIZE);
        end
      end
      S_DATA: begin
        // Address and data are registered here so they are stable for the
        // whole load cycle; instr_mem writes combinationally.
        if (asm_valid) begin
          mem_in_d  = asm_word;
          mem_adr_d = ww_q;
          state_d   = S_WRITE;
        end
      end
      S_WRITE: begin
        ww_d    = ww_inc;
        state_d = (ww_inc == n_q) ? S_DONE : S_DATA;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      n_q       <= 32'd0;
      ww_q      <= 32'd0;
      mem_adr_q <= 32'd0;
      mem_in_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      ww_q      <= ww_d;
      mem_adr_q <= mem_adr_d;
      mem_in_q  <= mem_in_d;
    end
  end

  // Gated with rst_n so a reset landing on a WRITE cycle cannot write.
  assign mem_load      = rst_n && (state_q == S_WRITE);
  assign mem_adr       = mem_adr_q;
  assign mem_in        = mem_in_q;
  assign busy          = (state_q == S_HDR) || (state_q == S_DATA) ||
                         (state_q == S_WRITE);
  assign done          = (state_q == S_DONE);
  assign err           = (state_q == S_ERR);
  assign words_written = ww_q;

endmodule
